// File: rtl/ff_sync_chain.sv
// ff_sync_chain: STAGES-deep flop chain bringing d into the dest_clk domain, one chain per bit
module ff_sync_chain #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             dest_clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (STAGES < 2) begin : g_chk
    $error("ff_sync_chain: STAGES must be >= 2");
  end
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", shreg_extract = "no" *)
  logic [WIDTH-1:0] stage_q [STAGES] = '{default: RST_VAL};
  logic [WIDTH-1:0] stage_d [STAGES];
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge dest_clk) begin
    if (srst) stage_q <= '{default: RST_VAL};
    else stage_q <= stage_d;
  end
  assign q = stage_q[STAGES-1];
endmodule

// File: tb/tb_ff_sync_chain.sv
// tb_ff_sync_chain: scoreboard bench for three synchroniser configurations against a history-based model
module tb_ff_sync_chain;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sa, da, sb, sc, dc;
  logic [7:0] db;
  logic qa, qc;
  logic [7:0] qb;
  int tests = 0, fails = 0, n = 0;
  logic [7:0] d_h [3][1024];
  logic r_h [3][1024];
  logic [7:0] qa_exp [$], qb_exp [$], qc_exp [$];
  ff_sync_chain #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0)) u_a (.dest_clk(clk), .srst(sa), .d(da), .q(qa));
  ff_sync_chain #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00)) u_b (.dest_clk(clk), .srst(sb), .d(db), .q(qb));
  ff_sync_chain #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b1)) u_c (.dest_clk(clk), .srst(sc), .d(dc), .q(qc));
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask
  // q after edge m is the d captured STAGES-1 edges earlier, unless an srst edge lies in that window
  function automatic logic [7:0] exp_q(input int w, input int s, input logic [7:0] rv, input int m);
    if (m < s) return rv;
    for (int k = m - s + 1; k <= m; k++) if (r_h[w][k]) return rv;
    return d_h[w][m-s+1];
  endfunction
  initial forever begin
    @(posedge clk);
    n++;
    d_h[0][n] = {7'b0, da}; r_h[0][n] = sa;
    d_h[1][n] = db;         r_h[1][n] = sb;
    d_h[2][n] = {7'b0, dc}; r_h[2][n] = sc;
    qa_exp.push_back(exp_q(0, 2, 8'h00, n));
    qb_exp.push_back(exp_q(1, 3, 8'h00, n));
    qc_exp.push_back(exp_q(2, 2, 8'h01, n));
  end
  initial begin
    logic [7:0] ea, eb, ec;
    forever begin
      @(posedge clk);
      #1;
      if (qa_exp.size() == 0 || qb_exp.size() == 0 || qc_exp.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard_empty at t=%0t: got empty queue expected entry", $time);
      end else begin
        ea = qa_exp.pop_front(); eb = qb_exp.pop_front(); ec = qc_exp.pop_front();
        check("qa", {7'b0, qa}, {7'b0, ea[0]});
        check("qb", qb, eb);
        check("qc", {7'b0, qc}, {7'b0, ec[0]});
        @(negedge clk);
        check("qa_mid", {7'b0, qa}, {7'b0, ea[0]});
        check("qb_mid", qb, eb);
        check("qc_mid", {7'b0, qc}, {7'b0, ec[0]});
      end
    end
  end
  task automatic step(input logic ar, ad, br, input logic [7:0] bd, input logic cr, cd);
    @(posedge clk);
    #($urandom_range(2, 4));
    sa = ar; da = ad; sb = br; db = bd; sc = cr; dc = cd;
  endtask
  initial begin
    logic [7:0] seq [4];
    sa = 0; da = 1; sb = 0; db = 8'h5A; sc = 0; dc = 0;
    #1;
    check("qa_powerup", {7'b0, qa}, 8'h00);
    check("qb_powerup", qb, 8'h00);
    check("qc_powerup", {7'b0, qc}, 8'h01);
    repeat (4) step(0, 1, 0, 8'h5A, 0, 0);
    repeat (3) step(1, 1, 1, 8'hFF, 1, 1);
    seq = '{8'h00, 8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 4; i++) step(0, 1, 0, seq[i], 0, i < 2);
    repeat (4) step(0, 1, 0, 8'hFF, 0, 0);
    step(0, 1, 1, 8'hFF, 0, 0);
    repeat (5) step(0, 1, 0, 8'hFF, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 1), $urandom_range(0, 15) == 0,
           8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
